mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. It sits directly downstream of the execute stage and consumes that stage's ALU result, store data and decoded fields. Loads and stores go to a single-port data memory over a req/ack handshake, with byte-lane generation and load sign/zero extension. All other instructions pass through with one registered cycle, and the stage presents a registered write-back bundle to the register-file write port.

---
 rtl/mem_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline.
//   Loads/stores go to a single-port data memory over a req/ack handshake,
//   with byte-lane generation for stores and sign/zero extension for loads.
//   Every other instruction passes through with one registered cycle.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   ex_valid, opcode, funct3, rd, alu_result, rs2_data   execute-stage bundle
//   mem_ready             stage idle; can accept an instruction
//   dmem_req/we/addr/wdata/be, dmem_rdata/ack           data-memory port
//   wb_valid/we/rd/data   registered write-back bundle
//   mem_err               one-cycle pulse: misaligned, illegal funct3, timeout
module mem_stage #(
  parameter int unsigned DMEM_TIMEOUT = 15  // 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  output logic        mem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [7:0] CNT_LAST  = 8'(DMEM_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;     // load type of the pending access
  logic [1:0]  off_q, off_d;   // byte offset of the pending access
  logic [4:0]  rd_q, rd_d;     // destination of the pending access
  logic        wbv_q, wbv_d;
  logic        wbwe_q, wbwe_d;
  logic [4:0]  wbrd_q, wbrd_d;
  logic [31:0] wbdata_q, wbdata_d;
  logic        err_q, err_d;

  // decode of the incoming instruction
  logic        is_load, is_store, is_branch, f3_ok, misal, acc_ok, acc_bad;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  // load extraction from the returned word
  logic [31:0] ld_shift, ld_data;

  always_comb begin
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    f3_ok     = is_load  ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                         : (funct3 inside {3'b000, 3'b001, 3'b010});
    // funct3[1:0] encodes access size for every legal load/store
    misal     = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
    acc_ok    = (is_load || is_store) && f3_ok && !misal;
    acc_bad   = (is_load || is_store) && !(f3_ok && !misal);

    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << alu_result[1:0];
        st_wdata = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rs2_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = rs2_data;
      end
    endcase
  end

  always_comb begin
    ld_shift = dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}},  ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  // next-state / output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    f3_d     = f3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    wbv_d    = 1'b0;
    err_d    = 1'b0;
    wbwe_d   = wbwe_q;
    wbrd_d   = wbrd_q;
    wbdata_d = wbdata_q;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (acc_ok) begin
            state_d = S_ACCESS;
            cnt_d   = 8'd0;
            we_d    = is_store;
            addr_d  = {alu_result[31:2], 2'b00};
            wdata_d = is_store ? st_wdata : 32'd0;
            be_d    = is_store ? st_be : 4'b0000;
            f3_d    = funct3;
            off_d   = alu_result[1:0];
            rd_d    = rd;
          end else if (acc_bad) begin
            wbv_d  = 1'b1;
            err_d  = 1'b1;
            wbwe_d = 1'b0;
            wbrd_d = rd;
          end else begin
            wbv_d    = 1'b1;
            wbwe_d   = !is_branch && (rd != 5'd0);
            wbrd_d   = rd;
            wbdata_d = alu_result;
          end
        end
      end
      S_ACCESS: begin
        if (dmem_ack) begin
          // ack in the last permitted cycle beats the timeout
          state_d = S_IDLE;
          wbv_d   = 1'b1;
          wbrd_d  = rd_q;
          if (we_q) begin
            wbwe_d = 1'b0;
          end else begin
            wbwe_d   = (rd_q != 5'd0);
            wbdata_d = ld_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          wbv_d   = 1'b1;
          err_d   = 1'b1;
          wbwe_d  = 1'b0;
          wbrd_d  = rd_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'b0000;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      rd_q     <= 5'd0;
      wbv_q    <= 1'b0;
      wbwe_q   <= 1'b0;
      wbrd_q   <= 5'd0;
      wbdata_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      wbv_q    <= wbv_d;
      wbwe_q   <= wbwe_d;
      wbrd_q   <= wbrd_d;
      wbdata_q <= wbdata_d;
      err_q    <= err_d;
    end
  end

  assign mem_ready  = (state_q == S_IDLE);
  assign dmem_req   = (state_q == S_ACCESS);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign wb_valid   = wbv_q;
  assign wb_we      = wbwe_q;
  assign wb_rd      = wbrd_q;
  assign wb_data    = wbdata_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int TO = 3;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;
  localparam logic [6:0] ADDI = 7'b0010011, ALUR = 7'b0110011, JAL = 7'b1101111;

  logic clk = 1'b0, reset = 1'b1;
  logic ex_valid = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [4:0] rd = '0;
  logic [31:0] alu_result = '0, rs2_data = '0, dmem_rdata = '0;
  logic dmem_ack = 1'b0;
  logic mem_ready, dmem_req, dmem_we, wb_valid, wb_we, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0] dmem_be;
  logic [4:0] wb_rd;

  int n_cmp = 0, n_bad = 0;

  mem_stage #(.DMEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .opcode(opcode),
    .funct3(funct3), .rd(rd), .alu_result(alu_result), .rs2_data(rs2_data),
    .mem_ready(mem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, rs2, rdata;
    int          ack_k;     // req cycle in which ack arrives; 0 = never
    logic        req, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        err, chk_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [4:0] rdi,
      logic [31:0] alu, logic [31:0] rs2, logic [31:0] rdata, int ack_k,
      logic req, logic we, logic [31:0] addr, logic [3:0] be, logic [31:0] wdata,
      logic wbwe, logic [31:0] wbdata, logic err, logic chkd);
    vec_t v;
    v.op = op; v.f3 = f3; v.rd = rdi; v.alu = alu; v.rs2 = rs2; v.rdata = rdata;
    v.ack_k = ack_k; v.req = req; v.we = we; v.addr = addr; v.be = be;
    v.wdata = wdata; v.wb_we = wbwe; v.wb_data = wbdata; v.err = err; v.chk_data = chkd;
    return v;
  endfunction

  // Reference model: expected behaviour from the instruction-level rules.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int sz, off;
    bit legal;
    logic [31:0] raw, lim;
    r.req = 0; r.we = 0; r.addr = 0; r.be = 0; r.wdata = 0;
    r.wb_we = 0; r.wb_data = 0; r.err = 0; r.chk_data = 0;
    if (v.op == LD || v.op == ST) begin
      sz = 1 << v.f3[1:0];
      legal = (v.op == LD) ? (v.f3 != 3 && v.f3 != 6 && v.f3 != 7) : (v.f3 < 3);
      off = int'(v.alu % 4);
      if (!legal || (v.alu % sz) != 0) r.err = 1;
      else begin
        r.req = 1;
        r.we = (v.op == ST);
        r.addr = v.alu - off;
        if (v.ack_k == 0 || v.ack_k > TO) r.err = 1;
        if (v.op == ST) begin
          for (int i = 0; i < 4; i++) begin
            r.be[i] = (i >= off && i < off + sz);
            r.wdata[8*i +: 8] = v.rs2[8*(i % sz) +: 8];
          end
        end else if (!r.err) begin
          raw = v.rdata >> (8 * off);
          if (sz < 4) begin
            lim = 32'd1 << (8 * sz);
            raw = raw & (lim - 1);
            if (!v.f3[2] && raw >= (lim >> 1)) raw = raw - lim;
          end
          r.wb_data = raw;
          r.wb_we = (v.rd != 0);
          r.chk_data = 1;
        end
      end
    end else begin
      r.wb_we = (v.op != BR) && (v.rd != 0);
      r.wb_data = v.alu;
      r.chk_data = (v.op != BR);
    end
    return r;
  endfunction

  // Drive one instruction from an idle stage, play the memory side, and check.
  task automatic run_vec(input vec_t v, input string tag);
    ex_valid = 1; opcode = v.op; funct3 = v.f3; rd = v.rd;
    alu_result = v.alu; rs2_data = v.rs2;
    chk({tag, ".ready_in"}, 32'(mem_ready), 1);
    @(negedge clk);
    if (v.req) begin
      for (int c = 1; c <= TO + 1; c++) begin
        // unrelated traffic while busy must be ignored
        ex_valid = 1; opcode = ADDI; rd = 5'($urandom); alu_result = $urandom;
        chk({tag, ".req"}, 32'(dmem_req), 1);
        chk({tag, ".ready_busy"}, 32'(mem_ready), 0);
        chk({tag, ".wbv_busy"}, 32'(wb_valid), 0);
        chk({tag, ".we"}, 32'(dmem_we), 32'(v.we));
        chk({tag, ".addr"}, dmem_addr, v.addr);
        chk({tag, ".be"}, 32'(dmem_be), 32'(v.be));
        if (v.we) chk({tag, ".wdata"}, dmem_wdata, v.wdata);
        if (c == v.ack_k) begin dmem_ack = 1; dmem_rdata = v.rdata; end
        @(negedge clk);
        dmem_ack = 0; dmem_rdata = $urandom;
        if (c == v.ack_k || c == TO) break;
      end
    end
    ex_valid = 0;
    chk({tag, ".wb_valid"}, 32'(wb_valid), 1);
    chk({tag, ".mem_err"}, 32'(mem_err), 32'(v.err));
    chk({tag, ".wb_we"}, 32'(wb_we), 32'(v.wb_we));
    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
    if (v.chk_data) chk({tag, ".wb_data"}, wb_data, v.wb_data);
    chk({tag, ".req_done"}, 32'(dmem_req), 0);
    chk({tag, ".ready_done"}, 32'(mem_ready), 1);
    @(negedge clk);
    chk({tag, ".wbv_pulse"}, 32'(wb_valid), 0);
    chk({tag, ".err_pulse"}, 32'(mem_err), 0);
  endtask

  vec_t tbl[16];
  vec_t rv;
  logic [6:0] ops[7];

  initial begin
    // hand-derived vectors:        op  f3 rd  alu           rs2           rdata        k  req we addr          be       wdata         wbwe wbdata        err chk
    tbl[0]  = mk(ADDI,0,5, 32'h1234,     0,            0,            0, 0,0, 0,            4'b0000, 0,            1, 32'h1234,     0, 1);
    tbl[1]  = mk(LD,  0,7, 32'h103,      0,            32'h80FF_0000,1, 1,0, 32'h100,      4'b0000, 0,            1, 32'hFFFF_FF80,0, 1);
    tbl[2]  = mk(ST,  1,4, 32'h202,      32'hDEAD_BEEF,0,            1, 1,1, 32'h200,      4'b1100, 32'hBEEF_BEEF,0, 0,            0, 0);
    tbl[3]  = mk(LD,  2,6, 32'h6,        0,            0,            0, 0,0, 0,            4'b0000, 0,            0, 0,            1, 0);
    tbl[4]  = mk(LD,  2,8, 32'h10,       0,            32'h1111_2222,0, 1,0, 32'h10,       4'b0000, 0,            0, 0,            1, 0);
    tbl[5]  = mk(LD,  2,9, 32'h10,       0,            32'h1234_5678,3, 1,0, 32'h10,       4'b0000, 0,            1, 32'h1234_5678,0, 1);
    tbl[6]  = mk(LD,  5,10,32'h102,      0,            32'h80FF_0000,2, 1,0, 32'h100,      4'b0000, 0,            1, 32'h0000_80FF,0, 1);
    tbl[7]  = mk(LD,  1,11,32'h102,      0,            32'h80FF_0000,2, 1,0, 32'h100,      4'b0000, 0,            1, 32'hFFFF_80FF,0, 1);
    tbl[8]  = mk(LD,  4,12,32'h101,      0,            32'h0000_A500,1, 1,0, 32'h100,      4'b0000, 0,            1, 32'h0000_00A5,0, 1);
    tbl[9]  = mk(ST,  0,13,32'h301,      32'h0000_00AB,0,            2, 1,1, 32'h300,      4'b0010, 32'hABAB_ABAB,0, 0,            0, 0);
    tbl[10] = mk(ST,  2,14,32'h400,      32'hCAFE_F00D,0,            1, 1,1, 32'h400,      4'b1111, 32'hCAFE_F00D,0, 0,            0, 0);
    tbl[11] = mk(BR,  0,3, 32'h55,       0,            0,            0, 0,0, 0,            4'b0000, 0,            0, 0,            0, 0);
    tbl[12] = mk(LD,  3,15,32'h20,       0,            0,            0, 0,0, 0,            4'b0000, 0,            0, 0,            1, 0);
    tbl[13] = mk(ST,  4,16,32'h20,       0,            0,            0, 0,0, 0,            4'b0000, 0,            0, 0,            1, 0);
    tbl[14] = mk(ALUR,0,0, 32'h777,      0,            0,            0, 0,0, 0,            4'b0000, 0,            0, 32'h777,      0, 1);
    tbl[15] = mk(LD,  2,0, 32'h44,       0,            32'h9999_0000,1, 1,0, 32'h44,       4'b0000, 0,            0, 32'h9999_0000,0, 1);

    // reset state
    @(negedge clk);
    chk("rst.ready", 32'(mem_ready), 1);
    chk("rst.req", 32'(dmem_req), 0);
    chk("rst.wb_valid", 32'(wb_valid), 0);
    chk("rst.mem_err", 32'(mem_err), 0);
    chk("rst.outs", dmem_addr | dmem_wdata | wb_data | 32'(dmem_be) | 32'(wb_rd)
        | 32'(dmem_we) | 32'(wb_we), 0);
    reset = 0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // back-to-back non-memory instructions
    ex_valid = 1; opcode = ADDI; rd = 1; alu_result = 32'hA1;
    @(negedge clk);
    chk("b2b.wbv0", 32'(wb_valid), 1);
    chk("b2b.data0", wb_data, 32'hA1);
    chk("b2b.ready", 32'(mem_ready), 1);
    opcode = JAL; rd = 2; alu_result = 32'hB2;
    @(negedge clk);
    ex_valid = 0;
    chk("b2b.wbv1", 32'(wb_valid), 1);
    chk("b2b.rd1", 32'(wb_rd), 2);
    chk("b2b.data1", wb_data, 32'hB2);
    @(negedge clk);
    chk("b2b.idle", 32'(wb_valid), 0);

    // ack while no request is ignored
    dmem_ack = 1; dmem_rdata = 32'h1;
    @(negedge clk);
    dmem_ack = 0;
    chk("strayack.wbv", 32'(wb_valid), 0);
    chk("strayack.ready", 32'(mem_ready), 1);

    // reset during an access
    ex_valid = 1; opcode = LD; funct3 = 3'b010; rd = 20; alu_result = 32'h80;
    @(negedge clk);
    ex_valid = 0;
    chk("rstacc.req_before", 32'(dmem_req), 1);
    #2 reset = 1;
    #1;
    chk("rstacc.req", 32'(dmem_req), 0);
    chk("rstacc.ready", 32'(mem_ready), 1);
    chk("rstacc.addr", dmem_addr, 0);
    @(negedge clk);
    reset = 0;
    dmem_ack = 1; dmem_rdata = 32'hFACE_FACE;
    @(negedge clk);
    dmem_ack = 0;
    chk("lateack.wbv", 32'(wb_valid), 0);
    chk("lateack.req", 32'(dmem_req), 0);
    @(negedge clk);
    chk("lateack.wbv2", 32'(wb_valid), 0);
    chk("lateack.ready", 32'(mem_ready), 1);

    // randomized instructions against the reference model
    ops[0] = LD; ops[1] = ST; ops[2] = BR; ops[3] = ADDI; ops[4] = ALUR; ops[5] = JAL;
    for (int i = 0; i < 80; i++) begin
      ops[6] = 7'($urandom);
      rv.op = (i % 3 == 0) ? ops[$urandom_range(0, 6)] : ops[$urandom_range(0, 1)];
      rv.f3 = 3'($urandom);
      rv.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rv.alu = $urandom;
      rv.rs2 = $urandom;
      rv.rdata = $urandom;
      rv.ack_k = $urandom_range(0, TO + 1);
      run_vec(model(rv), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
